uart_tx: RTL and testbench

//  Serial UART transmitter; the transmit-side counterpart of the RX path.

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 80 ++++++++
 tb/tb_uart_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side handshake bundle (tx_start, din in; txd, tx_busy, tx_done out)
interface uart_tx_if #(parameter int SIZE = 8);
  logic            tx_start;
  logic [SIZE-1:0] din;
  logic            txd;
  logic            tx_busy;
  logic            tx_done;
  modport master (output tx_start, din, input txd, tx_busy, tx_done);
  modport slave  (input tx_start, din, output txd, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART serialiser (clk, sync active-low rst_n, bus: tx_start/din in, txd/tx_busy/tx_done out)
module uart_tx #(
  parameter int SIZE         = 8,
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_MODE  = 0
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic [SIZE-1:0] sh, sh_n;
  logic            txd, txd_n, par, par_n, tick;
  assign tick        = cnt == LAST_CNT;
  assign bus.txd     = txd;
  assign bus.tx_busy = state != IDLE;
  assign bus.tx_done = state == STOP && tick;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      txd   <= 1'b1;
      par   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      txd   <= txd_n;
      par   <= par_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = state == IDLE ? '0 : tick ? '0 : cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    txd_n   = txd;
    par_n   = par;
    case (state)
      IDLE: if (bus.tx_start) begin
        state_n = START;
        sh_n    = bus.din;
        par_n   = (^bus.din) ^ (PARITY_MODE == 2);
        idx_n   = '0;
        txd_n   = 1'b0;
      end
      START: if (tick) begin
        state_n = DATA;
        txd_n   = sh[0];
        sh_n    = sh >> 1;
      end
      DATA: if (tick) begin
        if (idx == LAST_IDX) begin
          state_n = PARITY_MODE != 0 ? PARITY : STOP;
          txd_n   = PARITY_MODE != 0 ? par : 1'b1;
        end else begin
          idx_n = idx + 1'b1;
          txd_n = sh[0];
          sh_n  = sh >> 1;
        end
      end
      PARITY: if (tick) begin
        state_n = STOP;
        txd_n   = 1'b1;
      end
      STOP: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed table-driven bench for uart_tx in all three parity modes
module tb_uart_tx;
  localparam int N = 4;
  typedef struct {
    logic [7:0] din;
    logic       pe;
    logic       po;
    int         ign_at;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  vec_t vecs[8];
  always #5 clk = ~clk;
  uart_tx_if #(.SIZE(8)) b0 ();
  uart_tx_if #(.SIZE(8)) b1 ();
  uart_tx_if #(.SIZE(8)) b2 ();
  uart_tx #(.SIZE(8), .CLKS_PER_BIT(N), .PARITY_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  uart_tx #(.SIZE(8), .CLKS_PER_BIT(N), .PARITY_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  uart_tx #(.SIZE(8), .CLKS_PER_BIT(N), .PARITY_MODE(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  wire [2:0] txd_o  = {b2.txd, b1.txd, b0.txd};
  wire [2:0] busy_o = {b2.tx_busy, b1.tx_busy, b0.tx_busy};
  wire [2:0] done_o = {b2.tx_done, b1.tx_done, b0.tx_done};
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic drive(input int m, input logic s, input logic [7:0] d);
    if (m == 0) begin b0.tx_start = s; b0.din = d; end
    else if (m == 1) begin b1.tx_start = s; b1.din = d; end
    else begin b2.tx_start = s; b2.din = d; end
  endtask
  task automatic drive_all(input logic s, input logic [7:0] d);
    for (int m = 0; m < 3; m++) drive(m, s, d);
  endtask
  // k = cycle number within the frame (1 = first cycle after accept); k outside 1..F means idle
  task automatic expect_cycle(input int m, input logic [7:0] din, input logic pe, input logic po,
                              input int k, input string tag);
    int f, b;
    logic e;
    f = (m == 0 ? 10 : 11) * N;
    b = (k - 1) / N;
    if (k < 1 || k > f) e = 1'b1;
    else if (b == 0) e = 1'b0;
    else if (b <= 8) e = din[b-1];
    else if (m != 0 && b == 9) e = m == 1 ? pe : po;
    else e = 1'b1;
    chk($sformatf("%s m%0d c%0d txd", tag, m, k), txd_o[m], e);
    chk($sformatf("%s m%0d c%0d busy", tag, m, k), busy_o[m], k >= 1 && k <= f);
    chk($sformatf("%s m%0d c%0d done", tag, m, k), done_o[m], k == f);
  endtask
  task automatic expect_all(input logic [7:0] din, input logic pe, input logic po,
                            input int k, input string tag);
    for (int m = 0; m < 3; m++) expect_cycle(m, din, pe, po, k, tag);
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    drive_all(1'b1, v.din);
    @(posedge clk); #1;
    drive_all(1'b0, v.din);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      expect_all(v.din, v.pe, v.po, k, tag);
      if (k == v.ign_at) drive_all(1'b1, 8'hFF);
      if (k == v.ign_at + 1) drive_all(1'b0, 8'hFF);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 0};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 0};
    vecs[5] = '{8'h01, 1'b1, 1'b0, 0};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 0};
    vecs[7] = '{8'h5A, 1'b0, 1'b1, 10};
    drive_all(1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      expect_all(8'h00, 1'b0, 1'b0, 0, "idle");
    end
    for (int v = 0; v < 8; v++) run_vec(vecs[v], $sformatf("vec%0d", v));
    @(posedge clk); #1;
    drive(0, 1'b1, 8'h3C);
    @(posedge clk); #1;
    for (int k = 1; k <= 82; k++) begin
      @(negedge clk);
      if (k <= 41) expect_cycle(0, 8'h3C, 1'b0, 1'b1, k, "b2b_a");
      else expect_cycle(0, 8'hC3, 1'b0, 1'b1, k - 41, "b2b_b");
      if (k == 20) drive(0, 1'b1, 8'hC3);
      if (k == 42) drive(0, 1'b0, 8'hC3);
    end
    @(posedge clk); #1;
    drive_all(1'b1, 8'hA5);
    @(posedge clk); #1;
    drive_all(1'b0, 8'hA5);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      expect_all(8'hA5, 1'b0, 1'b1, k, "pre_rst");
    end
    rst_n = 1'b0;
    @(negedge clk);
    expect_all(8'h00, 1'b0, 1'b0, 0, "rst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_all(8'h00, 1'b0, 1'b0, 0, "post_rst");
    end
    run_vec(vecs[1], "after_rst");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
